// File: rtl/seq_detect_moore_param.sv
// Moore serial pattern detector: runtime-programmable pattern of 1..MAX_LEN bits, overlap select, valid qualifier.
// Define SEQDET_COUNT_EN to build the saturating match counter; otherwise match_count is tied to 0.
module seq_detect_moore_param #(
  parameter int unsigned          MAX_LEN     = 8,
  parameter logic [MAX_LEN-1:0]   RST_PATTERN = MAX_LEN'(8'b0000_0110),
  parameter int unsigned          RST_LEN     = 3,
  parameter bit                   RST_OVERLAP = 1'b1,
  parameter int unsigned          CNT_W       = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic                             in_bit,
  input  logic                             cfg_load,
  input  logic [MAX_LEN-1:0]               cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]     cfg_len,
  input  logic                             cfg_overlap,
  output logic                             det,
  output logic                             det_pulse,
  output logic [CNT_W-1:0]                 match_count
);

  localparam int unsigned        LEN_W     = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   RST_LEN_L = (RST_LEN > MAX_LEN) ? MAX_LEN_L : LEN_W'(RST_LEN);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_MATCH  = 1'b1
  } state_t;

  typedef struct packed {
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
  } cfg_t;

  cfg_t               cfg;
  cfg_t               cfg_nxt;
  state_t             state;
  state_t             state_nxt;
  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_nxt;
  logic [MAX_LEN-1:0] mask;
  logic               match_nxt;
  logic               det_pulse_nxt;

  // State register; det mirrors the match state so it never sees in_bit combinationally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg.pattern <= RST_PATTERN;
      cfg.len     <= RST_LEN_L;
      cfg.overlap <= RST_OVERLAP;
      state       <= ST_SEARCH;
      hist        <= '0;
      fill        <= '0;
      det         <= 1'b0;
      det_pulse   <= 1'b0;
    end else begin
      cfg         <= cfg_nxt;
      state       <= state_nxt;
      hist        <= hist_nxt;
      fill        <= fill_nxt;
      det         <= (state_nxt == ST_MATCH);
      det_pulse   <= det_pulse_nxt;
    end
  end

  // Next-state: a load wins over a data bit; an accepted bit shifts in and re-evaluates the window
  always_comb begin
    cfg_nxt       = cfg;
    state_nxt     = state;
    hist_nxt      = hist;
    fill_nxt      = fill;
    mask          = '0;
    match_nxt     = 1'b0;
    det_pulse_nxt = 1'b0;

    if (cfg_load) begin
      cfg_nxt.pattern = cfg_pattern;
      cfg_nxt.len     = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
      cfg_nxt.overlap = cfg_overlap;
      hist_nxt        = '0;
      fill_nxt        = '0;
      state_nxt       = ST_SEARCH;
    end else if (in_valid) begin
      hist_nxt = {hist[MAX_LEN-2:0], in_bit};
      // Non-overlapping mode: the bit after a match opens a fresh window
      if (!cfg.overlap && (state == ST_MATCH)) begin
        fill_nxt = LEN_W'(1);
      end else if (fill < cfg.len) begin
        fill_nxt = fill + LEN_W'(1);
      end else begin
        fill_nxt = cfg.len;
      end
      mask          = {MAX_LEN{1'b1}} >> (MAX_LEN_L - cfg.len);
      match_nxt     = (cfg.len != '0) && (fill_nxt == cfg.len) &&
                      (((hist_nxt ^ cfg.pattern) & mask) == '0);
      state_nxt     = match_nxt ? ST_MATCH : ST_SEARCH;
      det_pulse_nxt = match_nxt;
    end
  end

`ifdef SEQDET_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Saturating match counter, cleared by a configuration load
  always_comb begin
    cnt_nxt = cnt;
    if (cfg_load) begin
      cnt_nxt = '0;
    end else if (det_pulse_nxt && (cnt != CNT_MAX)) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign match_count = cnt;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Self-checking bench for seq_detect_moore_param: vector table with a scoreboard queue plus reset corner cases.
module tb_seq_detect_moore_param;

`ifdef SEQDET_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic       vld;
    logic       b;
    logic       load;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       edet;
    logic       epulse;
  } vec_t;

  typedef struct packed {
    logic       det;
    logic       pulse;
    logic [7:0] cnt;
    logic [1:0] sat;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_bit;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       det;
  logic       det_pulse;
  logic [7:0] match_count;
  logic       det_s;
  logic       pulse_s;
  logic [1:0] count_s;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;
  int   vec_idx  = 0;

  seq_detect_moore_param u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .det(det), .det_pulse(det_pulse),
    .match_count(match_count)
  );

  seq_detect_moore_param #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .det(det_s), .det_pulse(pulse_s),
    .match_count(count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input logic vld, input logic b, input logic ed, input logic ep);
    vec_t r;
    r = '0;
    r.vld = vld; r.b = b; r.edet = ed; r.epulse = ep;
    return r;
  endfunction

  function automatic vec_t ld(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                              input logic vld, input logic b);
    vec_t r;
    r = '0;
    r.load = 1'b1; r.pat = pat; r.len = len; r.ovl = ovl; r.vld = vld; r.b = b;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0d expected %0d", nm, vec_idx, act, expv);
    end
  endtask

  // Drive one vector at negedge, queue its expectation, compare just after the next rising edge
  task automatic apply(input vec_t x);
    exp_t e;
    @(negedge clk);
    in_valid    = x.vld;
    in_bit      = x.b;
    cfg_load    = x.load;
    cfg_pattern = x.pat;
    cfg_len     = x.len;
    cfg_overlap = x.ovl;
    if (x.load) exp_cnt = 0;
    else if (x.epulse && exp_cnt != 255) exp_cnt++;
    e.det   = x.edet;
    e.pulse = x.epulse;
    e.cnt   = COUNT_EN ? 8'(exp_cnt) : 8'd0;
    e.sat   = COUNT_EN ? ((exp_cnt > 3) ? 2'd3 : 2'(exp_cnt)) : 2'd0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("det", det, e.det);
    chk("det_pulse", det_pulse, e.pulse);
    chk("match_count", match_count, e.cnt);
    chk("sat_count", count_s, e.sat);
    vec_idx++;
  endtask

  initial begin
    logic [7:0] clamp_pat;
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;

    // Reset config "110" overlapping: single match, then the next bit clears det
    tbl.push_back(v(1,1,0,0)); tbl.push_back(v(1,1,0,0));
    tbl.push_back(v(1,0,1,1)); tbl.push_back(v(1,1,0,0));
    // Run of ones then 0,1,1,0: two matches, none during the run
    tbl.push_back(ld(8'b110, 4'd3, 1'b1, 1'b0, 1'b0));
    tbl.push_back(v(1,1,0,0)); tbl.push_back(v(1,1,0,0)); tbl.push_back(v(1,1,0,0));
    tbl.push_back(v(1,1,0,0)); tbl.push_back(v(1,0,1,1)); tbl.push_back(v(1,1,0,0));
    tbl.push_back(v(1,1,0,0)); tbl.push_back(v(1,0,1,1));
    // 1010 overlapping: two matches
    tbl.push_back(ld(8'b1010, 4'd4, 1'b1, 1'b0, 1'b0));
    tbl.push_back(v(1,1,0,0)); tbl.push_back(v(1,0,0,0)); tbl.push_back(v(1,1,0,0));
    tbl.push_back(v(1,0,1,1)); tbl.push_back(v(1,1,0,0)); tbl.push_back(v(1,0,1,1));
    // 1010 non-overlapping: one match
    tbl.push_back(ld(8'b1010, 4'd4, 1'b0, 1'b0, 1'b0));
    tbl.push_back(v(1,1,0,0)); tbl.push_back(v(1,0,0,0)); tbl.push_back(v(1,1,0,0));
    tbl.push_back(v(1,0,1,1)); tbl.push_back(v(1,1,0,0)); tbl.push_back(v(1,0,0,0));
    // Idle gaps: bits offered without in_valid are ignored; det holds, pulse lasts one cycle
    tbl.push_back(ld(8'b110, 4'd3, 1'b1, 1'b0, 1'b0));
    tbl.push_back(v(1,1,0,0)); tbl.push_back(v(1,1,0,0));
    for (int i = 0; i < 5; i++) tbl.push_back(v(0,0,0,0));
    tbl.push_back(v(1,0,1,1));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0,1,1,0));
    tbl.push_back(v(1,1,0,0));
    // Load together with a valid bit: the bit is dropped, so 1,0 does not complete 110
    tbl.push_back(ld(8'b110, 4'd3, 1'b1, 1'b1, 1'b1));
    tbl.push_back(v(1,1,0,0)); tbl.push_back(v(1,0,0,0));
    // Length 0 disables detection
    tbl.push_back(ld(8'b0, 4'd0, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 20; i++) tbl.push_back(v(1, 1'($urandom), 0, 0));
    // Length 12 clamps to 8
    clamp_pat = 8'b1011_0011;
    tbl.push_back(ld(clamp_pat, 4'd12, 1'b1, 1'b0, 1'b0));
    for (int i = 7; i >= 0; i--) tbl.push_back(v(1, clamp_pat[i], i == 0, i == 0));
    // Pattern bits above len-1 are ignored
    tbl.push_back(ld(8'b1111_0110, 4'd3, 1'b1, 1'b0, 1'b0));
    tbl.push_back(v(1,1,0,0)); tbl.push_back(v(1,1,0,0)); tbl.push_back(v(1,0,1,1));
    // Five matches: 2-bit counter saturates at 3
    tbl.push_back(ld(8'b110, 4'd3, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 5; k++) begin
      tbl.push_back(v(1,1,0,0)); tbl.push_back(v(1,1,0,0)); tbl.push_back(v(1,0,1,1));
    end

    #2;
    chk("reset_det", det, 1'b0);
    chk("reset_det_pulse", det_pulse, 1'b0);
    chk("reset_match_count", match_count, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Asynchronous reset between edges while det is high
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_det", det, 1'b0);
    chk("async_reset_det_pulse", det_pulse, 1'b0);
    chk("async_reset_match_count", match_count, 8'd0);
    chk("async_reset_sat_count", count_s, 2'd0);
    in_valid = 1'b0;
    cfg_load = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
    // Default configuration must be back in force after reset
    apply(v(1,1,0,0));
    apply(v(1,1,0,0));
    apply(v(1,0,1,1));
    apply(v(0,0,1,0));

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
